traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Independent checker on the lamp outputs of the traffic light controller.
//  - Samples red/yellow/green every clk and tracks the legal sequence R -> RY -> G -> Y -> R.
//  - Checks that each phase lasts between MIN_PHASE and its per-phase maximum.
//  - On any violation, latches a sticky fault and asserts force_all_red so the system can put
//    the lamps into the ALL_RED emergency state.
//  - Counts completed light cycles for diagnostics.
// PARAMETERS
//  MIN_PHASE   2    minimum legal phase length, in cycles, applied to every phase
//  RED_MAX     32   maximum legal R phase length (cycles)
//  RY_MAX      16   maximum legal RY phase length
//  GREEN_MAX   40   maximum legal G phase length; an early exit because of the sensor is legal
//  YELLOW_MAX  16   maximum legal Y phase length
//  CNT_W       8    phase counter width; the counter saturates at 2^CNT_W-1
// PORTS
//  clk            in   1   clock, rising edge
//  reset_n        in   1   reset, asynchronous, active-low
//  red            in   1   red lamp, synchronous to clk
//  yellow         in   1   yellow lamp
//  green          in   1   green lamp
//  clear          in   1   sync pulse: clears the fault and re-enters SYNC
//  locked         out  1   1 = tracking the sequence (not in SYNC or FAULT)
//  phase          out  2   current phase: 0=R 1=RY 2=G 3=Y; valid only when locked=1
//  fault          out  1   sticky violation flag
//  fault_code     out  3   0 none, 1 illegal pattern, 2 illegal transition, 3 too short, 4 too long
//  force_all_red  out  1   equal to fault
//  cycle_count    out  16  completed Y->R transitions; wraps 0xFFFF -> 0
// BEHAVIOUR
//  Reset values: locked=0, phase=0, fault=0, fault_code=0, force_all_red=0, cycle_count=0,
//  state=SYNC, cnt=0.
//  Patterns {r,y,g}:
//  - Legal: 100=R, 110=RY, 001=G, 010=Y.
//  - Illegal: any other pattern (000, 011, 101, 111). Illegal patterns are checked in every
//    state except FAULT.
//  States and transitions:
//  - SYNC
//    - Waits for pattern R; all other legal patterns are ignored.
//    - On the first R: go to TRACK, phase=0, cnt=1, first_phase=1.
//  - TRACK
//    - Same pattern as the previous sample: cnt increments (saturating).
//    - cnt reaching phase_max+1: fault code 4.
//    - Pattern change, legal successor: check the ending phase; if cnt < MIN_PHASE and
//      first_phase=0, fault code 3. Otherwise advance phase, set cnt=1, clear first_phase.
//      The first phase acquired from SYNC is only partially observed, so it gets no
//      min check; it still gets the max check.
//    - Pattern change, any other legal pattern: fault code 2.
//    - The Y->R transition increments cycle_count.
//  - FAULT
//    - Latched: locked=0, fault=1, fault_code holds the first fault seen.
//    - Lamp inputs are ignored; only clear or reset leaves this state.
//  Latency and clear:
//  - A violation in the inputs sampled at edge k is visible on fault and fault_code from edge k.
//    The outputs are registered, so they appear 1 cycle after the inputs are presented.
//  - Priority when several violations occur on one sample: 1 > 2 > 3 > 4.
//  - clear=1 at edge k, in any state:
//    - Next state is SYNC; fault and fault_code are cleared; cnt=0.
//    - The sample taken at edge k is discarded, even if it contains a violation.
//    - cycle_count is kept.
//  - Reset asserted mid-operation: all registers return to their reset values immediately,
//    asynchronously.
// TESTING
//  Bench parameters: MIN_PHASE=2, RED_MAX=8, RY_MAX=3, GREEN_MAX=10, YELLOW_MAX=4.
//  1. Legal loop R5,RY2,G6,Y3 repeated twice, starting from SYNC:
//     -> fault stays 0, locked=1 from the first R sample, cycle_count=2,
//        phase steps 0,1,2,3.
//  2. Legal loop, but G held 11 cycles:
//     -> fault=1 and code=4 on the 11th G sample; force_all_red=1.
//  3. R followed directly by G:
//     -> code=2 on the first G sample.
//     Then pulse clear, then R then RY:
//     -> fault=0, locked=1; the first R gets no min check.
//  4. Locked; RY held for 1 cycle, then G:
//     -> code=3 on the G sample.
//     Same run with pattern 101 injected on the same sample:
//     -> code=1, since code 1 wins priority.
//  5. Pattern 111 while in SYNC:
//     -> fault=1, code=1.
//     Then clear and an illegal pattern asserted in the same cycle:
//     -> fault=0, state SYNC.
//  6. Assert reset_n=0 mid-G with cycle_count=3:
//     -> all outputs 0 immediately.
//     Preload cycle_count to 0xFFFF, then one Y->R transition:
//     -> cycle_count=0.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Independent checker for the traffic light lamp outputs.
// Tracks R -> RY -> G -> Y -> R, enforces phase lengths, latches faults.
module traffic_light_monitor #(
  parameter int unsigned MIN_PHASE  = 2,
  parameter int unsigned RED_MAX    = 32,
  parameter int unsigned RY_MAX     = 16,
  parameter int unsigned GREEN_MAX  = 40,
  parameter int unsigned YELLOW_MAX = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        red,
  input  logic        yellow,
  input  logic        green,
  input  logic        clear,
  output logic        locked,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        force_all_red,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_RY = 2'd1;
  localparam logic [1:0] PH_G  = 2'd2;
  localparam logic [1:0] PH_Y  = 2'd3;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_PAT   = 3'd1;
  localparam logic [2:0] F_TRANS = 3'd2;
  localparam logic [2:0] F_SHORT = 3'd3;
  localparam logic [2:0] F_LONG  = 3'd4;

  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_PHASE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [2:0]        code_q, code_d;
  logic [15:0]       cycle_count_q, cycle_count_d;

  logic [2:0]        pat;
  logic              pat_ok;
  logic [1:0]        pat_ph;
  logic [1:0]        succ_ph;
  logic [CNT_W-1:0]  ph_max;
  logic [CNT_W-1:0]  cnt_inc;

  assign pat     = {red, yellow, green};
  assign succ_ph = phase_q + 2'd1;

  always_comb begin
    pat_ok = 1'b1;
    pat_ph = PH_R;
    unique case (1'b1)
      pat == 3'b100: pat_ph = PH_R;
      pat == 3'b110: pat_ph = PH_RY;
      pat == 3'b001: pat_ph = PH_G;
      pat == 3'b010: pat_ph = PH_Y;
      default:       pat_ok = 1'b0;
    endcase
  end

  always_comb begin
    ph_max = CNT_W'(RED_MAX);
    unique case (phase_q)
      PH_R:    ph_max = CNT_W'(RED_MAX);
      PH_RY:   ph_max = CNT_W'(RY_MAX);
      PH_G:    ph_max = CNT_W'(GREEN_MAX);
      PH_Y:    ph_max = CNT_W'(YELLOW_MAX);
      default: ph_max = CNT_W'(RED_MAX);
    endcase
  end

  // Saturating so a stuck lamp cannot wrap the counter back into range.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    cnt_d         = cnt_q;
    first_d       = first_q;
    code_d        = code_q;
    cycle_count_d = cycle_count_q;
    if (clear) begin
      state_d = S_SYNC;
      phase_d = PH_R;
      cnt_d   = '0;
      first_d = 1'b0;
      code_d  = F_NONE;
    end else begin
      unique case (state_q)
        S_SYNC: begin
          if (!pat_ok) begin
            state_d = S_FAULT;
            code_d  = F_PAT;
          end else if (pat_ph == PH_R) begin
            state_d = S_TRACK;
            phase_d = PH_R;
            cnt_d   = CNT_ONE;
            first_d = 1'b1;
          end
        end
        S_TRACK: begin
          if (!pat_ok) begin
            state_d = S_FAULT;
            code_d  = F_PAT;
          end else if (pat_ph == phase_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc > ph_max) begin
              state_d = S_FAULT;
              code_d  = F_LONG;
            end
          end else if (pat_ph != succ_ph) begin
            state_d = S_FAULT;
            code_d  = F_TRANS;
          end else if (!first_q && cnt_q < MIN_LEN) begin
            // The phase acquired from SYNC was only partly seen.
            state_d = S_FAULT;
            code_d  = F_SHORT;
          end else begin
            phase_d = pat_ph;
            cnt_d   = CNT_ONE;
            first_d = 1'b0;
            if (phase_q == PH_Y) begin
              cycle_count_d = cycle_count_q + 16'd1;
            end
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_SYNC;
      phase_q       <= PH_R;
      cnt_q         <= '0;
      first_q       <= 1'b0;
      code_q        <= F_NONE;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cnt_q         <= cnt_d;
      first_q       <= first_d;
      code_q        <= code_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign locked        = (state_q == S_TRACK);
  assign phase         = phase_q;
  assign fault         = (state_q == S_FAULT);
  assign fault_code    = code_q;
  assign force_all_red = (state_q == S_FAULT);
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor.
// Expected outputs are queued as lamps are driven and popped after each edge.
module tb_traffic_light_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        red, yellow, green, clear;
  logic        locked;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic        force_all_red;
  logic [15:0] cycle_count;

  int checks = 0;
  int passes = 0;

  localparam logic [2:0] P_R   = 3'b100;
  localparam logic [2:0] P_RY  = 3'b110;
  localparam logic [2:0] P_G   = 3'b001;
  localparam logic [2:0] P_Y   = 3'b010;
  localparam logic [2:0] P_101 = 3'b101;
  localparam logic [2:0] P_111 = 3'b111;
  localparam logic [2:0] P_000 = 3'b000;

  typedef struct packed {
    logic        lk;
    logic [1:0]  ph;
    logic        ft;
    logic [2:0]  cd;
    logic        far;
    logic [15:0] cc;
  } obs_t;

  typedef struct {
    logic [2:0] p;
    logic       c;
    obs_t       e;
  } st_t;

  obs_t sb[$];
  st_t  plan_q[$];

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .MIN_PHASE (2),
    .RED_MAX   (8),
    .RY_MAX    (3),
    .GREEN_MAX (10),
    .YELLOW_MAX(4),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .red          (red),
    .yellow       (yellow),
    .green        (green),
    .clear        (clear),
    .locked       (locked),
    .phase        (phase),
    .fault        (fault),
    .fault_code   (fault_code),
    .force_all_red(force_all_red),
    .cycle_count  (cycle_count)
  );

  function automatic obs_t ex(logic lk, logic [1:0] ph, logic ft,
                              logic [2:0] cd, logic [15:0] cc);
    obs_t r;
    r.lk = lk; r.ph = ph; r.ft = ft;
    r.cd = cd; r.far = ft; r.cc = cc;
    return r;
  endfunction

  function automatic obs_t obs();
    obs_t r;
    r = {locked, phase, fault, fault_code, force_all_red, cycle_count};
    return r;
  endfunction

  // phase is only meaningful while locked
  function automatic obs_t msk(obs_t x, logic lk);
    obs_t r = x;
    if (!lk) r.ph = 2'd0;
    return r;
  endfunction

  task automatic lamps(input logic [2:0] p, input logic c);
    {red, yellow, green} = p;
    clear = c;
  endtask

  task automatic plan(input logic [2:0] p, input logic c, input obs_t e);
    st_t s;
    s.p = p; s.c = c; s.e = e;
    plan_q.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    lamps(P_Y, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    obs_t o, e;
    reset_n = 1'b0;
    lamps(P_Y, 1'b0);
    #2;
    o = obs();
    e = ex(0, 0, 0, 0, 16'd0);
    checks++;
    if (o !== e)
      $display("FAIL reset_state: got %h want %h", o, e);
    else passes++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_legal_loop();
    obs_t o, e;
    st_t s;
    int lens[4] = '{5, 2, 6, 3};
    logic [2:0] pats[4] = '{P_R, P_RY, P_G, P_Y};
    logic [15:0] cc = 0;
    logic [1:0] ph;
    do_reset();
    for (int l = 0; l < 2; l++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < lens[p]; k++) begin
          if (l == 1 && p == 0 && k == 0) cc++;
          ph = p[1:0];
          plan(pats[p], 0, ex(1, ph, 0, 0, cc));
        end
    cc++;
    plan(P_R, 0, ex(1, 0, 0, 0, cc));
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL legal_loop: got %h want %h", o, e);
      else passes++;
    end
  endtask

  task automatic test_green_too_long();
    obs_t o, e;
    st_t s;
    do_reset();
    repeat (3) plan(P_R, 0, ex(1, 0, 0, 0, 0));
    repeat (2) plan(P_RY, 0, ex(1, 1, 0, 0, 0));
    repeat (10) plan(P_G, 0, ex(1, 2, 0, 0, 0));
    plan(P_G, 0, ex(0, 0, 1, 4, 0));
    plan(P_Y, 0, ex(0, 0, 1, 4, 0));
    plan(P_111, 0, ex(0, 0, 1, 4, 0));
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL green_too_long: got %h want %h", o, e);
      else passes++;
    end
  endtask

  task automatic test_illegal_transition_and_clear();
    obs_t o, e;
    st_t s;
    do_reset();
    repeat (3) plan(P_R, 0, ex(1, 0, 0, 0, 0));
    plan(P_G, 0, ex(0, 0, 1, 2, 0));
    plan(P_R, 1, ex(0, 0, 0, 0, 0));
    plan(P_R, 0, ex(1, 0, 0, 0, 0));
    plan(P_RY, 0, ex(1, 1, 0, 0, 0));
    plan(P_RY, 0, ex(1, 1, 0, 0, 0));
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL bad_transition_clear: got %h want %h", o, e);
      else passes++;
    end
  endtask

  task automatic test_too_short_and_priority();
    obs_t o, e;
    st_t s;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      repeat (3) plan(P_R, 0, ex(1, 0, 0, 0, 0));
      plan(P_RY, 0, ex(1, 1, 0, 0, 0));
      if (run == 0) plan(P_G, 0, ex(0, 0, 1, 3, 0));
      else          plan(P_101, 0, ex(0, 0, 1, 1, 0));
      while (plan_q.size() > 0) begin
        s = plan_q.pop_front();
        lamps(s.p, s.c);
        sb.push_back(s.e);
        tick();
        e = sb.pop_front();
        o = obs();
        checks++;
        if (msk(o, e.lk) !== msk(e, e.lk))
          $display("FAIL too_short run%0d: got %h want %h", run, o, e);
        else passes++;
      end
    end
  endtask

  task automatic test_sync_illegal_and_clear();
    obs_t o, e;
    st_t s;
    do_reset();
    plan(P_111, 0, ex(0, 0, 1, 1, 0));
    plan(P_000, 1, ex(0, 0, 0, 0, 0));
    plan(P_Y, 0, ex(0, 0, 0, 0, 0));
    plan(P_G, 0, ex(0, 0, 0, 0, 0));
    plan(P_R, 0, ex(1, 0, 0, 0, 0));
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL sync_illegal_clear: got %h want %h", o, e);
      else passes++;
    end
  endtask

  task automatic test_reset_and_wrap();
    obs_t o, e;
    st_t s;
    logic [15:0] cc = 0;
    logic [2:0] pats[4] = '{P_R, P_RY, P_G, P_Y};
    logic [1:0] ph;
    do_reset();
    for (int l = 0; l < 3; l++)
      for (int p = 0; p < 4; p++)
        for (int k = 0; k < 2; k++) begin
          if (l > 0 && p == 0 && k == 0) cc++;
          ph = p[1:0];
          plan(pats[p], 0, ex(1, ph, 0, 0, cc));
        end
    cc++;
    plan(P_R, 0, ex(1, 0, 0, 0, cc));
    plan(P_R, 1, ex(0, 0, 0, 0, cc));
    plan(P_R, 0, ex(1, 0, 0, 0, cc));
    repeat (2) plan(P_RY, 0, ex(1, 1, 0, 0, cc));
    repeat (2) plan(P_G, 0, ex(1, 2, 0, 0, cc));
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL count_to_3: got %h want %h", o, e);
      else passes++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    o = obs();
    e = ex(0, 0, 0, 0, 16'd0);
    checks++;
    if (o !== e)
      $display("FAIL async_reset: got %h want %h", o, e);
    else passes++;
    lamps(P_Y, 1'b0);
    #1;
    reset_n = 1'b1;
    plan(P_Y, 0, ex(0, 0, 0, 0, 0));
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 2; k++) begin
        ph = p[1:0];
        plan(pats[p], 0, ex(1, ph, 0, 0, 0));
      end
    while (plan_q.size() > 0) begin
      s = plan_q.pop_front();
      lamps(s.p, s.c);
      sb.push_back(s.e);
      tick();
      e = sb.pop_front();
      o = obs();
      checks++;
      if (msk(o, e.lk) !== msk(e, e.lk))
        $display("FAIL after_reset: got %h want %h", o, e);
      else passes++;
    end
    force dut.cycle_count_q = 16'hFFFF;
    lamps(P_Y, 1'b0);
    sb.push_back(ex(1, 3, 0, 0, 16'hFFFF));
    @(posedge clk);
    #1;
    release dut.cycle_count_q;
    #1;
    e = sb.pop_front();
    o = obs();
    checks++;
    if (o !== e)
      $display("FAIL preload: got %h want %h", o, e);
    else passes++;
    lamps(P_R, 1'b0);
    sb.push_back(ex(1, 0, 0, 0, 16'h0000));
    tick();
    e = sb.pop_front();
    o = obs();
    checks++;
    if (o !== e)
      $display("FAIL count_wrap: got %h want %h", o, e);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0;
    lamps(P_Y, 1'b0);
    test_reset();
    test_legal_loop();
    test_green_too_long();
    test_illegal_transition_and_clear();
    test_too_short_and_priority();
    test_sync_illegal_and_clear();
    test_reset_and_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
